// File: rtl/vending_core_param.sv
// Multi-slot vending controller: coin credit, per-slot price/stock tables,
// selection/confirm/cancel, inactivity refund, alarm timer and sales total.
// All outputs come straight from registers.
module vending_core_param #(
   parameter int NUM_PRODUCTS   = 8,
   parameter int CODE_W         = $clog2(NUM_PRODUCTS),
   parameter int PRICE_W        = 8,
   parameter int SALES_W        = 12,
   parameter int STOCK_W        = 4,
   parameter int INIT_STOCK     = 5,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int ALARM_CYCLES   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_business_en,
   input  logic               i_coin_valid,
   input  logic [PRICE_W-1:0] i_coin_value,
   input  logic               i_sel_valid,
   input  logic [CODE_W-1:0]  i_sel_code,
   input  logic               i_confirm,
   input  logic               i_cancel,
   input  logic               i_price_wr,
   input  logic [CODE_W-1:0]  i_price_code,
   input  logic [PRICE_W-1:0] i_price_data,
   input  logic               i_restock_wr,
   input  logic [CODE_W-1:0]  i_restock_code,
   input  logic [STOCK_W-1:0] i_restock_qty,
   input  logic               i_sales_clear,
   output logic [PRICE_W-1:0] o_credit,
   output logic [PRICE_W-1:0] o_sel_price,
   output logic               o_change_valid,
   output logic [PRICE_W-1:0] o_change_amount,
   output logic               o_dispense_valid,
   output logic [CODE_W-1:0]  o_dispense_code,
   output logic               o_coin_reject,
   output logic               o_alarm,
   output logic [SALES_W-1:0] o_sales_total,
   output logic [1:0]         o_state
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam int ALM_W = $clog2(ALARM_CYCLES + 1);
   localparam int SW1   = SALES_W + 1;

   typedef enum logic [1:0] {ST_CLOSED, ST_IDLE, ST_CREDIT, ST_VEND} state_t;

   state_t             r_state, w_state_nxt;
   logic [PRICE_W-1:0] r_credit, w_credit_nxt;
   logic               r_sel_vld, w_sel_vld_nxt;
   logic [CODE_W-1:0]  r_sel_code, w_sel_code_nxt;
   logic [PRICE_W-1:0] r_sel_price;
   logic               r_chg_vld, w_chg_vld;
   logic [PRICE_W-1:0] r_chg_amt, w_chg_amt;
   logic               r_disp_vld, w_disp_vld;
   logic [CODE_W-1:0]  r_disp_code, w_disp_code;
   logic               r_reject, w_reject;
   logic               w_alarm_evt, w_vend;
   logic [ALM_W-1:0]   r_alarm_cnt;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic [SALES_W-1:0] r_sales;
   logic [PRICE_W-1:0] r_price [NUM_PRODUCTS];
   logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];

   logic [PRICE_W:0]   w_coin_sum;
   logic [SALES_W:0]   w_sales_sum;
   logic [PRICE_W-1:0] w_cur_price, w_nxt_sel_price;
   logic [STOCK_W-1:0] w_cur_stock;
   logic               w_can_vend, w_activity, w_tmo_hit;

   assign w_coin_sum  = {1'b0, r_credit} + {1'b0, i_coin_value};
   assign w_cur_price = r_price[r_sel_code];
   assign w_cur_stock = r_stock[r_sel_code];
   assign w_sales_sum = {1'b0, r_sales} + SW1'(w_cur_price);
   assign w_activity  = i_coin_valid | i_sel_valid | i_confirm | i_cancel;
   assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   // Price 0 marks an unpriced slot, never vendable.
   assign w_can_vend  = (r_state == ST_CREDIT) && r_sel_vld && (w_cur_price != '0) &&
                        (w_cur_stock != '0) && (r_credit >= w_cur_price);
   // sel_price follows the selection and any price write landing this cycle.
   assign w_nxt_sel_price = !w_sel_vld_nxt ? '0 :
                            (i_price_wr && i_price_code == w_sel_code_nxt) ? i_price_data :
                            r_price[w_sel_code_nxt];

   // Next-state and strobe decode; priority: close > cancel > confirm > coin > sel.
   always_comb begin
      w_state_nxt    = r_state;
      w_credit_nxt   = r_credit;
      w_sel_vld_nxt  = r_sel_vld;
      w_sel_code_nxt = r_sel_code;
      w_chg_vld      = 1'b0;
      w_chg_amt      = r_chg_amt;
      w_disp_vld     = 1'b0;
      w_disp_code    = r_disp_code;
      w_reject       = 1'b0;
      w_alarm_evt    = 1'b0;
      w_vend         = 1'b0;
      case (r_state)
         ST_CLOSED: begin
            if (i_coin_valid) begin
               w_reject    = 1'b1;
               w_alarm_evt = 1'b1;
            end
            if (i_business_en) w_state_nxt = ST_IDLE;
         end
         ST_IDLE, ST_CREDIT: begin
            if (!i_business_en) begin
               if (r_state == ST_CREDIT) begin
                  w_chg_vld = 1'b1;
                  w_chg_amt = r_credit;
               end
               w_credit_nxt  = '0;
               w_sel_vld_nxt = 1'b0;
               w_reject      = i_coin_valid;
               w_state_nxt   = ST_CLOSED;
            end else if (i_cancel && r_state == ST_CREDIT) begin
               w_chg_vld     = 1'b1;
               w_chg_amt     = r_credit;
               w_credit_nxt  = '0;
               w_sel_vld_nxt = 1'b0;
               w_reject      = i_coin_valid;
               w_state_nxt   = ST_IDLE;
            end else if (i_confirm && w_can_vend) begin
               w_vend        = 1'b1;
               w_disp_vld    = 1'b1;
               w_disp_code   = r_sel_code;
               w_chg_vld     = 1'b1;
               w_chg_amt     = r_credit - w_cur_price;
               w_credit_nxt  = '0;
               w_sel_vld_nxt = 1'b0;
               w_reject      = i_coin_valid;
               w_state_nxt   = ST_VEND;
            end else begin
               if (i_confirm) w_alarm_evt = 1'b1;
               if (i_coin_valid) begin
                  if (w_coin_sum[PRICE_W]) begin
                     w_reject    = 1'b1;
                     w_alarm_evt = 1'b1;
                  end else begin
                     w_credit_nxt = w_coin_sum[PRICE_W-1:0];
                  end
               end
               if (i_sel_valid && !i_confirm) begin
                  w_sel_vld_nxt  = 1'b1;
                  w_sel_code_nxt = i_sel_code;
               end
               if (r_state == ST_CREDIT && !w_activity && w_tmo_hit) begin
                  w_chg_vld     = 1'b1;
                  w_chg_amt     = r_credit;
                  w_credit_nxt  = '0;
                  w_sel_vld_nxt = 1'b0;
               end
               w_state_nxt = (w_credit_nxt != '0) ? ST_CREDIT : ST_IDLE;
            end
         end
         default: begin
            w_reject    = i_coin_valid;
            w_state_nxt = i_business_en ? ST_IDLE : ST_CLOSED;
         end
      endcase
   end

   // Main state, credit, selection and output strobe registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_CLOSED;
         r_credit    <= '0;
         r_sel_vld   <= 1'b0;
         r_sel_code  <= '0;
         r_sel_price <= '0;
         r_chg_vld   <= 1'b0;
         r_chg_amt   <= '0;
         r_disp_vld  <= 1'b0;
         r_disp_code <= '0;
         r_reject    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_credit    <= w_credit_nxt;
         r_sel_vld   <= w_sel_vld_nxt;
         r_sel_code  <= w_sel_code_nxt;
         r_sel_price <= w_nxt_sel_price;
         r_chg_vld   <= w_chg_vld;
         r_chg_amt   <= w_chg_amt;
         r_disp_vld  <= w_disp_vld;
         r_disp_code <= w_disp_code;
         r_reject    <= w_reject;
      end
   end

   // Price and stock tables; a restock write overrides a same-cycle decrement.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) begin
         if (i_rst) begin
            r_price[k] <= '0;
            r_stock[k] <= STOCK_W'(INIT_STOCK);
         end else begin
            if (i_price_wr && i_price_code == CODE_W'(k)) r_price[k] <= i_price_data;
            if (i_restock_wr && i_restock_code == CODE_W'(k))
               r_stock[k] <= i_restock_qty;
            else if (w_vend && r_sel_code == CODE_W'(k))
               r_stock[k] <= r_stock[k] - STOCK_W'(1);
         end
      end
   end

   // Saturating sales total; a clear alongside a vend leaves just that price.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_sales <= '0;
      else if (w_vend)
         r_sales <= i_sales_clear ? SALES_W'(w_cur_price) :
                    (w_sales_sum[SALES_W] ? '1 : w_sales_sum[SALES_W-1:0]);
      else if (i_sales_clear)
         r_sales <= '0;
   end

   // Inactivity counter: runs only in CREDIT with nonzero credit and no input activity.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_activity || r_credit == '0 || r_state != ST_CREDIT || w_chg_vld)
         r_tmo_cnt <= '0;
      else
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
   end

   // Alarm period counter; every event restarts the full period.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_alarm_cnt <= '0;
      else if (w_alarm_evt)
         r_alarm_cnt <= ALM_W'(ALARM_CYCLES);
      else if (r_alarm_cnt != '0)
         r_alarm_cnt <= r_alarm_cnt - ALM_W'(1);
   end

   assign o_credit         = r_credit;
   assign o_sel_price      = r_sel_price;
   assign o_change_valid   = r_chg_vld;
   assign o_change_amount  = r_chg_amt;
   assign o_dispense_valid = r_disp_vld;
   assign o_dispense_code  = r_disp_code;
   assign o_coin_reject    = r_reject;
   assign o_alarm          = (r_alarm_cnt != '0);
   assign o_sales_total    = r_sales;
   assign o_state          = r_state;

endmodule

// File: tb/tb_vending_core_param.sv
// Directed bench for vending_core_param: a vector table for the basic purchase
// flow plus hand sequences for overflow, alarm timing, stock/price checks,
// timeout, same-cycle priorities, sales saturation and closing.
module tb_vending_core_param;

   logic       clk, rst, be;
   logic       coin_v, sel_v, confirm, cancel, price_wr, restock_wr, sales_clear;
   logic [7:0] coin_val, price_data;
   logic [2:0] sel_code, price_code, restock_code;
   logic [3:0] restock_qty;
   logic [7:0] credit, sel_price, chg_amt;
   logic       chg_v, disp_v, rej, alarm;
   logic [2:0] disp_code;
   logic [11:0] sales;
   logic [1:0] state;

   int n_chk = 0;
   int n_fail = 0;
   int seen;

   vending_core_param dut (
      .i_clk(clk), .i_rst(rst), .i_business_en(be),
      .i_coin_valid(coin_v), .i_coin_value(coin_val),
      .i_sel_valid(sel_v), .i_sel_code(sel_code),
      .i_confirm(confirm), .i_cancel(cancel),
      .i_price_wr(price_wr), .i_price_code(price_code), .i_price_data(price_data),
      .i_restock_wr(restock_wr), .i_restock_code(restock_code), .i_restock_qty(restock_qty),
      .i_sales_clear(sales_clear),
      .o_credit(credit), .o_sel_price(sel_price),
      .o_change_valid(chg_v), .o_change_amount(chg_amt),
      .o_dispense_valid(disp_v), .o_dispense_code(disp_code),
      .o_coin_reject(rej), .o_alarm(alarm), .o_sales_total(sales), .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       be, coin_v;
      logic [7:0] coin_val;
      logic       sel_v;
      logic [2:0] sel_code;
      logic       confirm, cancel;
      logic [1:0] e_state;
      logic [7:0] e_credit, e_sel_price;
      logic       e_chg_v;
      logic [7:0] e_chg;
      logic       e_disp_v;
      logic [2:0] e_disp_code;
      logic       e_rej, e_alarm;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      coin_v = 0; sel_v = 0; confirm = 0; cancel = 0;
      price_wr = 0; restock_wr = 0; sales_clear = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic put_coin(input int v);
      coin_v = 1; coin_val = 8'(v); step(); clr();
   endtask

   task automatic set_price(input int c, input int p);
      price_wr = 1; price_code = 3'(c); price_data = 8'(p); step(); clr();
   endtask

   task automatic pick(input int c);
      sel_v = 1; sel_code = 3'(c); step(); clr();
   endtask

   // Full purchase with exact credit; restocks the slot while the coin goes in.
   task automatic vend(input int c, input int p, input logic clr_sales);
      coin_v = 1; coin_val = 8'(p);
      restock_wr = 1; restock_code = 3'(c); restock_qty = 4'd15;
      step(); clr();
      pick(c);
      confirm = 1; sales_clear = clr_sales; step(); clr();
      chk("vend.disp_v", disp_v, 1);
      chk("vend.disp_code", disp_code, c);
      step();
   endtask

   initial begin
      tbl[0]  = '{1,0,0, 0,0,0,0, 1,0,0,  0,0,0,0,0,0};
      tbl[1]  = '{1,1,10,0,0,0,0, 2,10,0, 0,0,0,0,0,0};
      tbl[2]  = '{1,1,10,0,0,0,0, 2,20,0, 0,0,0,0,0,0};
      tbl[3]  = '{1,1,10,0,0,0,0, 2,30,0, 0,0,0,0,0,0};
      tbl[4]  = '{1,0,0, 1,3,0,0, 2,30,25,0,0,0,0,0,0};
      tbl[5]  = '{1,0,0, 0,0,1,0, 3,0,0,  1,5,1,3,0,0};
      tbl[6]  = '{1,0,0, 0,0,0,0, 1,0,0,  0,5,0,3,0,0};
      tbl[7]  = '{1,0,0, 0,0,1,0, 1,0,0,  0,5,0,3,0,1};
      tbl[8]  = '{1,0,0, 0,0,0,1, 1,0,0,  0,5,0,3,0,1};
      tbl[9]  = '{1,1,7, 1,2,0,0, 2,7,0,  0,5,0,3,0,1};
      tbl[10] = '{1,0,0, 0,0,1,0, 2,7,0,  0,5,0,3,0,1};
      tbl[11] = '{1,1,5, 0,0,0,1, 1,0,0,  1,7,0,3,1,1};

      be = 0; coin_val = 0; sel_code = 0; price_code = 0; price_data = 0;
      restock_code = 0; restock_qty = 0;
      clr();
      rst = 1; idle(2); rst = 0;
      chk("rst.state", state, 0);
      chk("rst.credit", credit, 0);
      chk("rst.sales", sales, 0);
      chk("rst.alarm", alarm, 0);
      chk("rst.sel_price", sel_price, 0);
      chk("rst.chg_amt", chg_amt, 0);

      set_price(3, 25);
      for (int i = 0; i < 12; i++) begin
         be = tbl[i].be; coin_v = tbl[i].coin_v; coin_val = tbl[i].coin_val;
         sel_v = tbl[i].sel_v; sel_code = tbl[i].sel_code;
         confirm = tbl[i].confirm; cancel = tbl[i].cancel;
         step(); clr();
         chk($sformatf("row%0d.state", i), state, tbl[i].e_state);
         chk($sformatf("row%0d.credit", i), credit, tbl[i].e_credit);
         chk($sformatf("row%0d.sel_price", i), sel_price, tbl[i].e_sel_price);
         chk($sformatf("row%0d.chg_v", i), chg_v, tbl[i].e_chg_v);
         chk($sformatf("row%0d.chg_amt", i), chg_amt, tbl[i].e_chg);
         chk($sformatf("row%0d.disp_v", i), disp_v, tbl[i].e_disp_v);
         chk($sformatf("row%0d.disp_code", i), disp_code, tbl[i].e_disp_code);
         chk($sformatf("row%0d.reject", i), rej, tbl[i].e_rej);
         chk($sformatf("row%0d.alarm", i), alarm, tbl[i].e_alarm);
      end
      chk("buy.sales", sales, 25);
      chk("buy.stock3", dut.r_stock[3], 4);

      // Overflow rejection and alarm period
      idle(20);
      chk("ovf.alarm_quiet", alarm, 0);
      put_coin(100); put_coin(100); put_coin(50);
      chk("ovf.credit250", credit, 250);
      put_coin(10);
      chk("ovf.reject", rej, 1);
      chk("ovf.credit", credit, 250);
      chk("ovf.alarm0", alarm, 1);
      seen = 0;
      for (int i = 1; i < 16; i++) begin step(); if (!alarm) seen = 1; end
      chk("ovf.alarm_held", seen, 0);
      step();
      chk("ovf.alarm_off", alarm, 0);
      cancel = 1; step(); clr();
      chk("ovf.cancel_chg_v", chg_v, 1);
      chk("ovf.cancel_chg", chg_amt, 250);
      chk("ovf.cancel_state", state, 1);

      // Alarm retrigger restarts the full period
      confirm = 1; step(); clr();
      idle(8);
      confirm = 1; step(); clr();
      seen = 0;
      for (int i = 1; i < 16; i++) begin step(); if (!alarm) seen = 1; end
      chk("retrig.held", seen, 0);
      step();
      chk("retrig.off", alarm, 0);

      // Out of stock and unpriced slot
      restock_wr = 1; restock_code = 1; restock_qty = 0;
      price_wr = 1; price_code = 1; price_data = 10;
      step(); clr();
      put_coin(20);
      pick(1);
      chk("oos.sel_price", sel_price, 10);
      confirm = 1; step(); clr();
      chk("oos.alarm", alarm, 1);
      chk("oos.disp_v", disp_v, 0);
      chk("oos.credit", credit, 20);
      chk("oos.state", state, 2);
      idle(20);
      chk("nop.alarm_quiet", alarm, 0);
      pick(2);
      confirm = 1; step(); clr();
      chk("nop.alarm", alarm, 1);
      chk("nop.disp_v", disp_v, 0);
      chk("nop.credit", credit, 20);
      cancel = 1; step(); clr();
      chk("nop.cancel_chg", chg_amt, 20);

      // Inactivity refund
      put_coin(5);
      seen = 0;
      for (int i = 0; i < 999; i++) begin step(); if (chg_v) seen = 1; end
      chk("tmo.early", seen, 0);
      chk("tmo.state_before", state, 2);
      step();
      chk("tmo.chg_v", chg_v, 1);
      chk("tmo.chg", chg_amt, 5);
      chk("tmo.state", state, 1);
      chk("tmo.credit", credit, 0);

      // Activity at cycle 999 restarts the count
      put_coin(5);
      seen = 0;
      for (int i = 0; i < 998; i++) begin step(); if (chg_v) seen = 1; end
      pick(0);
      for (int i = 0; i < 999; i++) begin step(); if (chg_v) seen = 1; end
      chk("tmo2.early", seen, 0);
      chk("tmo2.state_before", state, 2);
      step();
      chk("tmo2.chg_v", chg_v, 1);
      chk("tmo2.state", state, 1);

      // Confirm + coin in one cycle, then cancel + confirm
      set_price(4, 30);
      put_coin(30);
      pick(4);
      confirm = 1; coin_v = 1; coin_val = 10; step(); clr();
      chk("cc.disp_v", disp_v, 1);
      chk("cc.disp_code", disp_code, 4);
      chk("cc.chg_v", chg_v, 1);
      chk("cc.chg", chg_amt, 0);
      chk("cc.reject", rej, 1);
      chk("cc.credit", credit, 0);
      chk("cc.state_vend", state, 3);
      step();
      chk("cc.state_idle", state, 1);
      put_coin(30);
      pick(4);
      confirm = 1; cancel = 1; step(); clr();
      chk("xc.chg_v", chg_v, 1);
      chk("xc.chg", chg_amt, 30);
      chk("xc.disp_v", disp_v, 0);
      chk("xc.state", state, 1);
      chk("xc.stock4", dut.r_stock[4], 4);
      chk("xc.sales", sales, 55);

      // Sales saturation and clear coincident with a vend
      sales_clear = 1; step(); clr();
      chk("sal.clear", sales, 0);
      set_price(5, 255); set_price(6, 10); set_price(7, 7);
      for (int i = 0; i < 16; i++) vend(5, 255, 0);
      vend(6, 10, 0);
      chk("sal.4090", sales, 4090);
      vend(3, 25, 0);
      chk("sal.sat", sales, 4095);
      vend(3, 25, 0);
      chk("sal.sat_hold", sales, 4095);
      vend(7, 7, 1);
      chk("sal.clr_vend", sales, 7);

      // Closing with credit refunds it
      put_coin(15);
      be = 0; step();
      chk("close.chg_v", chg_v, 1);
      chk("close.chg", chg_amt, 15);
      chk("close.state", state, 0);
      chk("close.credit", credit, 0);
      put_coin(3);
      chk("closed.reject", rej, 1);
      chk("closed.alarm", alarm, 1);
      chk("closed.credit", credit, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vending_core_param.md
Name: vending_core_param

Overview:
- Parametrised successor of the single-product vending controller.
- Manages NUM_PRODUCTS slots, each with a programmable price and a stock counter.
- Handles coin credit accumulation with overflow rejection, selection/confirm/cancel, inactivity auto-refund, timed alarm and a clearable sales total.
- Sits between the coin/product code decoders and the segment display drivers; all outputs are registered.

Parameters:
NUM_PRODUCTS, 8, number of product slots (>=2)
CODE_W, $clog2(NUM_PRODUCTS), width of product code
PRICE_W, 8, width of price, credit, change and coin value (unsigned)
SALES_W, 12, width of sales_total accumulator
STOCK_W, 4, width of per-slot stock counter
INIT_STOCK, 5, stock of every slot after reset
TIMEOUT_CYCLES, 1000, idle cycles with credit>0 before auto-refund
ALARM_CYCLES, 16, cycles alarm stays high per alarm event

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
business_en  in  1  1 = open for business; 0 = closed
coin_valid  in  1  one-cycle coin strobe
coin_value  in  PRICE_W  value of inserted coin
sel_valid  in  1  selection strobe
sel_code  in  CODE_W  selected product
confirm  in  1  purchase request strobe
cancel  in  1  refund request strobe
price_wr  in  1  price table write strobe
price_code  in  CODE_W  price table write index
price_data  in  PRICE_W  price to write
restock_wr  in  1  stock write strobe (absolute value)
restock_code  in  CODE_W  stock write index
restock_qty  in  STOCK_W  new stock value
sales_clear  in  1  clear sales_total
credit  out  PRICE_W  current accumulated credit
sel_price  out  PRICE_W  price of latched selection (0 if none)
change_valid  out  1  one-cycle change strobe
change_amount  out  PRICE_W  change value, held until next change_valid
dispense_valid  out  1  one-cycle dispense strobe
dispense_code  out  CODE_W  dispensed product, held until next dispense
coin_reject  out  1  one-cycle strobe: coin not accepted
alarm  out  1  alarm output
sales_total  out  SALES_W  saturating total of vended prices
state  out  2  0=CLOSED 1=IDLE 2=CREDIT 3=VEND

Behaviour:
- Reset: state=CLOSED; credit, sel_price, change_amount, dispense_code, sales_total, timeout counter, alarm counter = 0; all strobes 0; selection invalid; every price=0; every stock=INIT_STOCK.
- Latency: each input is sampled at posedge clk; its response appears on outputs after that same edge (1 cycle).
- CLOSED: business_en=1 -> IDLE. Coins rejected (coin_reject=1, alarm started). confirm, cancel and sel ignored. price_wr and restock_wr are accepted in every state.
- IDLE (credit=0), accepted coin -> CREDIT. CREDIT: further coins accumulate.
- Credit overflow: if credit+coin_value > 2^PRICE_W-1, the coin is rejected (coin_reject, alarm) and credit is unchanged.
- sel_valid latches sel_code in IDLE/CREDIT. sel_price tracks the latched slot's price, including live price_wr updates.
- confirm in CREDIT, valid only if: selection latched, price!=0 (price 0 = unpriced), stock!=0, credit>=price.
  - Invalid confirm: alarm, state unchanged.
  - Valid confirm: go to VEND for exactly 1 cycle. In VEND: dispense_valid=1, dispense_code=slot, stock-1, sales_total += price (saturates at 2^SALES_W-1), change_amount=credit-price, change_valid=1 (including change 0), credit=0, selection cleared. Next state: IDLE.
- confirm in IDLE (credit 0): alarm.
- cancel in CREDIT: change_amount=credit, change_valid, credit=0, selection cleared -> IDLE. cancel in IDLE: no effect.
- Timeout: counter resets on any coin/sel/confirm/cancel and while credit=0. When the counter reaches TIMEOUT_CYCLES-1 in CREDIT, perform the refund as for cancel.
- business_en=0 in IDLE/CREDIT -> refund any credit as cancel, then CLOSED. In VEND, finish the vend first, then close.
- Same-cycle priority: rst > business_en drop > cancel > confirm > coin > sel. A coin arriving with an accepted cancel or confirm, or during VEND, is rejected (coin_reject). A sel in the same cycle as confirm is ignored.
- restock_wr to the slot being decremented in VEND: the write wins.
- sales_clear in the same cycle as a VEND add: sales_total = price.
- Alarm: each alarm event reloads the counter to ALARM_CYCLES. alarm = (counter!=0). A retrigger while active restarts the full period.

Test Plan:
- Reset, business_en=1, price_wr slot3=25, coins 10,10,10, sel 3, confirm -> dispense_valid with code 3, change_amount=5, sales_total=25, stock[3]=4, credit=0, state IDLE.
- Credit 250 then coin 10 -> coin_reject, alarm high for 16 cycles, credit stays 250. Then cancel -> change_amount=250.
- restock slot1=0, price slot1=10, credit 20, sel 1, confirm -> alarm, no dispense, credit 20. Confirm on a slot with price 0 -> alarm.
- Credit 5, idle 1000 cycles -> change_valid with change_amount=5 on cycle 1000, state IDLE. Activity at cycle 999 restarts the count.
- Same cycle confirm (valid, credit 30, price 30) + coin 10 -> dispense, change 0, coin_reject. Same cycle cancel + confirm -> refund only.
- sales_total at 4090, vend price 25 -> 4095 (saturated). sales_clear coincident with a vend of price 7 -> sales_total 7. business_en drop with credit 15 -> change 15, state CLOSED.
